dcache_store_buffer: RTL
========================

// Module: dcache_store_buffer
// PURPOSE
//  Committed-store buffer directly upstream of the data-cache data RAM's byte-enable write port.
//  Queues committed stores (doubleword index, byte mask, data) and drains one per granted cycle.
//  Coalesces a store into the youngest entry when both target the same doubleword.
//  Forwards buffered bytes to loads, aligned with the RAM's 1-cycle read latency.
// PARAMETERS
//  DEPTH    4   entries; power of two, >=2
//  IDX_W    10  doubleword index width, matches the data RAM address
//  DATA_W   64  data width; byte lanes = DATA_W/8
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst_n          in   1       asynchronous active-low reset
//  st_valid_i     in   1       committed store offered
//  st_ready_o     out  1       store accepted when valid&ready
//  st_idx_i       in   IDX_W   store doubleword index
//  st_be_i        in   8       store byte mask (non-zero)
//  st_data_i      in   DATA_W  store data, lane-aligned
//  ram_wr_gnt_i   in   1       RAM write port free this cycle (refill has priority)
//  ram_wr_en_o    out  8       byte write enables to the RAM
//  ram_wr_addr_o  out  IDX_W   RAM write index
//  ram_wr_data_o  out  DATA_W  RAM write data
//  ld_en_i        in   1       load lookup, issued in the same cycle as the RAM rd_en
//  ld_idx_i       in   IDX_W   load doubleword index
//  ld_fwd_be_o    out  8       registered: lanes to override from the buffer
//  ld_fwd_data_o  out  DATA_W  registered: forwarded bytes, meaningful where ld_fwd_be_o=1
//  empty_o        out  1       no valid entries; used by fences
// BEHAVIOUR
//  Reset: all entries invalid, head=tail=count=0; st_ready_o=1, empty_o=1, ram_wr_en_o=0,
//   ram_wr_addr_o=0, ram_wr_data_o=0, ld_fwd_be_o=0, ld_fwd_data_o=0. Reset mid-drain drops all entries.
//  Circular FIFO: head=oldest, tail=next free; count is 0..DEPTH.
//  st_ready_o = (count<DEPTH) | coalesce_ok. It never depends on ram_wr_gnt_i.
//  coalesce_ok: count>0, entry[tail-1].idx==st_idx_i, and NOT (count==1 & drain this cycle).
//  Coalesce: merge per lane (be|=st_be; data lanes replaced where st_be=1); count unchanged.
//   Otherwise a store allocates at tail, then tail+1 and count+1. Pointers wrap mod DEPTH.
//  Drain: fires when count>0 & ram_wr_gnt_i. That cycle:
//   ram_wr_en_o=entry[head].be, ram_wr_addr_o=.idx, ram_wr_data_o=.data, combinationally.
//   At the clock edge, head+1 and count-1.
//   With no drain, ram_wr_en_o=0 and addr/data=0.
//  Push and drain in the same cycle: count unchanged. When full, a push is accepted only by coalescing.
//  Forwarding: on ld_en_i, per lane pick the youngest valid entry with matching idx and that lane's be set.
//   The result registers into ld_fwd_* one cycle later, aligned with the RAM rd_data.
//   The head entry draining in the lookup cycle is still included, because the RAM read returns old data.
//   A store accepted in the lookup cycle is excluded; the pipeline orders such loads after it.
//   With ld_en_i=0, ld_fwd_be_o clears to 0 next cycle.
//  empty_o = (count==0), from registered state.
// STRUCTURE
//  dcache_pkg: sb_entry_t {valid, idx[IDX_W], be[8], data[DATA_W]}, DCACHE_IDX_W, DCACHE_BYTES.
//  Sub-module sb_fwd_select: age-ordered per-lane priority mux, combinational, registered by the parent.
// TESTING
//  1 Reset then idle: all outputs 0, st_ready_o=1, empty_o=1.
//  2 Coalesce, gnt=0: push idx 0x3, be=0x0F, data 0x11111111 -> push idx 0x3, be=0xF0, data 0x22222222<<32.
//    Required: count=1. Then gnt=1: ram_wr_en_o=0xFF, data=0x2222222211111111, addr 0x3; empty_o=1 next cycle.
//  3 Full, gnt=0, DEPTH=4: fill idx 1,2,3,4 -> store idx 5: st_ready_o=0.
//    Store idx 4: accepted by coalescing. Raise gnt: drains in order 1,2,3,4.
//  4 Forwarding: entries idx 7 be 0x01 data 0xAA, then idx 8, then idx 7 be 0x03 data 0xBBCC.
//    ld_en idx 7 -> next cycle ld_fwd_be_o=0x03, lanes 0xBBCC (youngest wins).
//  5 Drain plus lookup collision: count=1 idx 9 draining with gnt=1, and ld_en idx 9 in the same cycle.
//    Required: forwarding still reports idx 9 bytes. A store to idx 9 in that cycle allocates a new entry, not a coalesce.
//  6 Async reset with 3 entries and gnt=1 mid-drain -> ram_wr_en_o=0 immediately, empty_o=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache store buffer.
// An entry holds one doubleword index, its byte mask and lane-aligned data.
package dcache_pkg;

   localparam int DCACHE_IDX_W  = 10;
   localparam int DCACHE_BYTES  = 8;
   localparam int DCACHE_DATA_W = DCACHE_BYTES * 8;

   typedef struct packed {
      logic                     valid;
      logic [DCACHE_IDX_W-1:0]  idx;
      logic [DCACHE_BYTES-1:0]  be;
      logic [DCACHE_DATA_W-1:0] data;
   } sb_entry_t;

   // Replace the byte lanes selected by be, keep the others.
   function automatic logic [DCACHE_DATA_W-1:0] lane_merge(
      input logic [DCACHE_DATA_W-1:0] old_data,
      input logic [DCACHE_DATA_W-1:0] new_data,
      input logic [DCACHE_BYTES-1:0]  be
   );
      logic [DCACHE_DATA_W-1:0] res;
      res = old_data;
      for (int l = 0; l < DCACHE_BYTES; l++) begin
         if (be[l]) res[l*8 +: 8] = new_data[l*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Per-lane load-forwarding select across the store buffer, combinational.
// Entries are walked oldest to youngest so the youngest matching byte wins.
module sb_fwd_select
   import dcache_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t                entries [DEPTH],
   input  logic [PTR_W-1:0]         head,
   input  logic [DCACHE_IDX_W-1:0]  ld_idx,
   output logic [DCACHE_BYTES-1:0]  fwd_be,
   output logic [DCACHE_DATA_W-1:0] fwd_data
);

   logic [PTR_W-1:0] slot;

   // NOTE: every output gets a default before the loop so no path leaves
   // it unassigned (no latch), and blocking '=' lets later, younger entries
   // overwrite earlier matches within the same evaluation.
   always_comb begin
      fwd_be   = '0;
      fwd_data = '0;
      slot     = head;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PTR_W'(k);
         for (int l = 0; l < DCACHE_BYTES; l++) begin
            if (entries[slot].valid && entries[slot].idx == ld_idx && entries[slot].be[l]) begin
               fwd_be[l]          = 1'b1;
               fwd_data[l*8 +: 8] = entries[slot].data[l*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dcache_store_buffer.sv
// Committed-store buffer in front of the data RAM byte-enable write port:
// circular FIFO with youngest-entry coalescing and registered load forwarding.
module dcache_store_buffer
   import dcache_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int IDX_W  = DCACHE_IDX_W,
   parameter int DATA_W = DCACHE_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [IDX_W-1:0]  st_idx_i,
   input  logic [7:0]        st_be_i,
   input  logic [DATA_W-1:0] st_data_i,
   input  logic              ram_wr_gnt_i,
   output logic [7:0]        ram_wr_en_o,
   output logic [IDX_W-1:0]  ram_wr_addr_o,
   output logic [DATA_W-1:0] ram_wr_data_o,
   input  logic              ld_en_i,
   input  logic [IDX_W-1:0]  ld_idx_i,
   output logic [7:0]        ld_fwd_be_o,
   output logic [DATA_W-1:0] ld_fwd_data_o,
   output logic              empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t          entries [DEPTH];
   logic [PTR_W-1:0]   head, tail, youngest;
   logic [CNT_W-1:0]   count;
   logic               drain, coalesce_ok, push, alloc;
   logic [7:0]         sel_be;
   logic [DATA_W-1:0]  sel_data;

   assign youngest = tail - PTR_W'(1);
   assign drain    = (count != '0) && ram_wr_gnt_i;

   // A lone entry leaving this cycle cannot absorb a store: it would be lost.
   assign coalesce_ok = (count != '0) && (entries[youngest].idx == st_idx_i)
                        && !((count == CNT_W'(1)) && drain);
   assign st_ready_o  = (count < CNT_W'(DEPTH)) || coalesce_ok;
   assign push        = st_valid_i && st_ready_o;
   assign alloc       = push && !coalesce_ok;

   assign ram_wr_en_o   = drain ? entries[head].be   : '0;
   assign ram_wr_addr_o = drain ? entries[head].idx  : '0;
   assign ram_wr_data_o = drain ? entries[head].data : '0;
   assign empty_o       = (count == '0);

   // Lookup sees pre-edge state: a draining head is included, a same-cycle store is not.
   sb_fwd_select #(.DEPTH(DEPTH)) u_fwd_select (
      .entries  (entries),
      .head     (head),
      .ld_idx   (ld_idx_i),
      .fwd_be   (sel_be),
      .fwd_data (sel_data)
   );

   // NOTE: the entry array is small, so it is fully reset along with the
   // pointers; state is updated with '<=' so every read sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         ld_fwd_be_o   <= '0;
         ld_fwd_data_o <= '0;
      end else begin
         if (push && coalesce_ok) begin
            entries[youngest].be   <= entries[youngest].be | st_be_i;
            entries[youngest].data <= lane_merge(entries[youngest].data, st_data_i, st_be_i);
         end else if (alloc) begin
            entries[tail] <= '{valid: 1'b1, idx: st_idx_i, be: st_be_i, data: st_data_i};
            tail          <= tail + PTR_W'(1);
         end
         if (drain) begin
            entries[head].valid <= 1'b0;
            head                <= head + PTR_W'(1);
         end
         if (alloc && !drain)      count <= count + CNT_W'(1);
         else if (!alloc && drain) count <= count - CNT_W'(1);
         ld_fwd_be_o   <= ld_en_i ? sel_be   : '0;
         ld_fwd_data_o <= ld_en_i ? sel_data : '0;
      end
   end

endmodule
